// File: rtl/popcnt_pkg.sv
// popcnt_pkg: shared state/mode types and the accumulator width helper
// for the popcount sequencer.
`default_nettype none

package popcnt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } popcnt_state_e;

  typedef enum logic {
    MODE_AND  = 1'b0,
    MODE_XNOR = 1'b1
  } popcnt_mode_e;

  // Per-word count needs BW_O+1 bits; summing up to 2**BW_LEN-1 words adds BW_LEN bits.
  function automatic int acc_width(input int bw_o, input int bw_len);
    return bw_o + 1 + bw_len;
  endfunction

endpackage

`default_nettype wire

// File: rtl/popcnt_word.sv
// popcnt_word: combinational population count of one 2**BW_O-bit word.
// Output is BW_O+1 bits wide so an all-ones word is representable.
`default_nettype none

module popcnt_word #(
  parameter int BW_O = 4
) (
  input  logic [(2**BW_O)-1:0] i_word,
  output logic [BW_O:0]        o_cnt
);

  localparam int BW_I = 2**BW_O;

  always_comb begin
    o_cnt = '0;
    for (int i = 0; i < BW_I; i++) begin
      o_cnt = o_cnt + {{BW_O{1'b0}}, i_word[i]};
    end
  end

endmodule

`default_nettype wire

// File: rtl/popcnt_seq.sv
// popcnt_seq: job sequencer accumulating per-word AND/XNOR popcounts over
// a multi-word vector, returning one registered sum per job.
`default_nettype none

module popcnt_seq
  import popcnt_pkg::*;
#(
  parameter int BW_O   = 4,
  parameter int BW_I   = 2**BW_O,
  parameter int BW_LEN = 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   i_start,
  input  logic [BW_LEN-1:0]                      i_len,
  input  logic                                   i_xnor,
  input  logic                                   i_abort,
  input  logic [BW_I-1:0]                        i_act,
  input  logic [BW_I-1:0]                        i_wgt,
  input  logic                                   i_valid,
  output logic                                   o_ready,
  output logic [acc_width(BW_O, BW_LEN)-1:0]     o_sum,
  output logic                                   o_valid,
  input  logic                                   i_ready,
  output logic                                   o_busy
);

  localparam int BW_ACC = acc_width(BW_O, BW_LEN);

  popcnt_state_e       state_q, state_d;
  popcnt_mode_e        mode_q, mode_d;
  logic [BW_LEN-1:0]   rem_q, rem_d;
  logic [BW_ACC-1:0]   acc_q, acc_d;

  logic [BW_I-1:0]     w_pre;
  logic [BW_O:0]       w_cnt;

  assign w_pre = (mode_q == MODE_XNOR) ? ~(i_act ^ i_wgt) : (i_act & i_wgt);

  popcnt_word #(
    .BW_O (BW_O)
  ) u_word (
    .i_word (w_pre),
    .o_cnt  (w_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= MODE_AND;
      rem_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
      acc_q   <= acc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    rem_d   = rem_q;
    acc_d   = acc_q;
    // Abort outranks a final beat or result handshake landing on the same edge.
    if (i_abort) begin
      state_d = IDLE;
      rem_d   = '0;
      acc_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_start) begin
            rem_d   = i_len;
            mode_d  = i_xnor ? MODE_XNOR : MODE_AND;
            acc_d   = '0;
            state_d = (i_len != '0) ? RUN : DONE;
          end
        end
        RUN: begin
          if (i_valid) begin
            acc_d = acc_q + {{(BW_ACC-BW_O-1){1'b0}}, w_cnt};
            rem_d = rem_q - BW_LEN'(1);
            if (rem_q == BW_LEN'(1)) begin
              state_d = DONE;
            end
          end
        end
        DONE: begin
          if (i_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign o_ready = (state_q == RUN);
  assign o_valid = (state_q == DONE);
  assign o_busy  = (state_q != IDLE);
  assign o_sum   = acc_q;

endmodule

`default_nettype wire

// File: tb/tb_popcnt_seq.sv
// tb_popcnt_seq: directed vector table plus hand-written corner sequences
// (backpressure, abort, mid-job reset, maximum length) for popcnt_seq.
`default_nettype none

module tb_popcnt_seq;

  logic        clk;
  logic        rst;
  logic        i_start;
  logic [7:0]  i_len;
  logic        i_xnor;
  logic        i_abort;
  logic [15:0] i_act;
  logic [15:0] i_wgt;
  logic        i_valid;
  logic        o_ready;
  logic [12:0] o_sum;
  logic        o_valid;
  logic        i_ready;
  logic        o_busy;

  int checks;
  int failures;

  popcnt_seq dut (
    .clk     (clk),
    .rst     (rst),
    .i_start (i_start),
    .i_len   (i_len),
    .i_xnor  (i_xnor),
    .i_abort (i_abort),
    .i_act   (i_act),
    .i_wgt   (i_wgt),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .o_sum   (o_sum),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_busy  (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          len;
    bit          xnr;
    logic [15:0] act;
    logic [15:0] wgt;
    int          gap;
    int          exp_sum;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_busy"},  int'(o_busy),  0);
    chk({name, "_valid"}, int'(o_valid), 0);
    chk({name, "_ready"}, int'(o_ready), 0);
  endtask

  task automatic start_job(input int len, input bit xnr);
    i_start = 1'b1;
    i_len   = 8'(len);
    i_xnor  = xnr;
    tick();
    i_start = 1'b0;
  endtask

  task automatic beat(input string name, input logic [15:0] a, input logic [15:0] w);
    chk({name, "_ready"}, int'(o_ready), 1);
    chk({name, "_novalid"}, int'(o_valid), 0);
    i_valid = 1'b1;
    i_act   = a;
    i_wgt   = w;
    tick();
    i_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    start_job(v.len, v.xnr);
    for (int b = 0; b < v.len; b++) begin
      for (int g = 0; g < ((b > 0) ? v.gap : 0); g++) begin
        i_valid = 1'b0;
        i_act   = 16'hFFFF;
        i_wgt   = 16'hFFFF;
        tick();
      end
      beat(v.name, v.act, v.wgt);
    end
    chk({v.name, "_valid"}, int'(o_valid), 1);
    chk({v.name, "_sum"},   int'(o_sum),   v.exp_sum);
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    chk({v.name, "_idle"},  int'(o_busy),  0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    i_start  = 1'b0;
    i_len    = '0;
    i_xnor   = 1'b0;
    i_abort  = 1'b0;
    i_act    = '0;
    i_wgt    = '0;
    i_valid  = 1'b0;
    i_ready  = 1'b0;

    vecs[0] = '{"xnor3",     3,   1'b1, 16'hFFFF, 16'hFFFF, 0, 48};
    vecs[1] = '{"and_gaps",  2,   1'b0, 16'h00FF, 16'h0F0F, 2, 8};
    vecs[2] = '{"zero_len",  0,   1'b1, 16'hFFFF, 16'hFFFF, 0, 0};
    vecs[3] = '{"xnor_comp", 4,   1'b1, 16'hA5A5, 16'h5A5A, 1, 0};
    vecs[4] = '{"and_two",   2,   1'b0, 16'hFFFF, 16'h8001, 0, 4};
    vecs[5] = '{"xnor_eq",   1,   1'b1, 16'h1234, 16'h1234, 0, 16};

    // Reset state, held and after release.
    #3;
    chk_idle("rst_hold");
    chk("rst_hold_sum", int'(o_sum), 0);
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk_idle("rst_rel");
    chk("rst_rel_sum", int'(o_sum), 0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Backpressure: result held while consumer stalls; stray beats ignored.
    start_job(1, 1'b1);
    beat("bp", 16'h0000, 16'h0000);
    i_valid = 1'b1;
    i_act   = 16'hFFFF;
    i_wgt   = 16'hFFFF;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_valid", int'(o_valid), 1);
      chk("bp_hold_sum",   int'(o_sum),   16);
      chk("bp_hold_ready", int'(o_ready), 0);
      tick();
    end
    i_valid = 1'b0;
    // A start during the handshake cycle must not be accepted.
    i_ready = 1'b1;
    i_start = 1'b1;
    i_len   = 8'd0;
    tick();
    i_ready = 1'b0;
    i_start = 1'b0;
    chk_idle("bp_after");
    tick();
    chk_idle("bp_after2");

    // Abort in RUN after one beat.
    start_job(4, 1'b1);
    beat("ab", 16'hFFFF, 16'hFFFF);
    i_abort = 1'b1;
    i_valid = 1'b1;
    tick();
    i_abort = 1'b0;
    i_valid = 1'b0;
    chk_idle("ab_after");
    chk("ab_after_sum", int'(o_sum), 0);
    tick();
    chk("ab_novalid", int'(o_valid), 0);
    run_vec('{"ab_restart", 1, 1'b1, 16'hFFFF, 16'hFFFF, 0, 16});

    // Abort coinciding with the final beat wins over it.
    start_job(1, 1'b1);
    i_abort = 1'b1;
    i_valid = 1'b1;
    tick();
    i_abort = 1'b0;
    i_valid = 1'b0;
    chk_idle("ab_last");
    tick();
    chk("ab_last_novalid", int'(o_valid), 0);

    // Abort coinciding with the result handshake.
    start_job(0, 1'b0);
    chk("ab_done_valid", int'(o_valid), 1);
    i_abort = 1'b1;
    i_ready = 1'b1;
    tick();
    i_abort = 1'b0;
    i_ready = 1'b0;
    chk_idle("ab_done");

    // Asynchronous reset mid-RUN takes effect before the next edge.
    start_job(4, 1'b1);
    beat("rr", 16'hFFFF, 16'hFFFF);
    chk("rr_sum_pre", int'(o_sum), 16);
    rst = 1'b1;
    #1;
    chk_idle("rr_async");
    chk("rr_async_sum", int'(o_sum), 0);
    tick();
    rst = 1'b0;
    tick();
    run_vec('{"rr_restart", 1, 1'b1, 16'hFFFF, 16'hFFFF, 0, 16});

    // Maximum length with start pulses held through RUN and DONE.
    start_job(255, 1'b1);
    i_start = 1'b1;
    i_len   = 8'd3;
    i_valid = 1'b1;
    i_act   = 16'hFFFF;
    i_wgt   = 16'hFFFF;
    for (int b = 0; b < 255; b++) begin
      if (b == 254) chk("max_ready_last", int'(o_ready), 1);
      tick();
    end
    i_valid = 1'b0;
    chk("max_valid", int'(o_valid), 1);
    chk("max_sum",   int'(o_sum),   4080);
    tick();
    chk("max_hold_valid", int'(o_valid), 1);
    chk("max_hold_sum",   int'(o_sum),   4080);
    i_start = 1'b0;
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    chk_idle("max_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
